reg_rotator: RTL and testbench

//  Parametrised bank of NREG registers, WIDTH bits each, with scheduled non-blocking

---
 rtl/reg_rotator.sv | 184 ++++++++++++++++++
 tb/tb_reg_rotator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_rotator.sv
// reg_rotator: bank of NREG registers with scheduled load / rotate /
// shift-with-fill / swap operations, accepted over a valid/ready handshake.
// Each step computes the whole next image from the current image.
module reg_rotator #(
  parameter int WIDTH = 8,
  parameter int NREG  = 3,
  parameter int IDX_W = 2,
  parameter int CNT_W = 4,
  parameter logic [NREG*WIDTH-1:0] RST_VAL = {8'd1, 8'd0, 8'd1}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [CNT_W-1:0]        cmd_steps,
  input  logic [IDX_W-1:0]        cmd_idx,
  input  logic [WIDTH-1:0]        cmd_data,
  output logic [NREG*WIDTH-1:0]   regs,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_ROTATE = 2'b01;
  localparam logic [1:0] OP_SHIFT  = 2'b10;
  localparam logic [1:0] OP_SWAP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                       state_r, state_nxt_s;
  logic [CNT_W-1:0]             cnt_r, cnt_nxt_s, cnt_load_s;
  logic [1:0]                   op_r;
  logic [IDX_W-1:0]             idx_r;
  logic [WIDTH-1:0]             data_r;
  logic                         bad_idx_r, bad_idx_s;
  logic                         accept_s;
  logic [NREG-1:0][WIDTH-1:0]   regs_r, regs_nxt_s;
  logic                         ready_r, busy_r, done_r, err_r, err_nxt_s;

  assign accept_s  = cmd_valid && ready_r;
  assign regs      = regs_r;
  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

  // Decode the incoming command: step count to load and index range error.
  always_comb begin
    cnt_load_s = CNT_W'(1);
    bad_idx_s  = 1'b0;
    if ((cmd_op == OP_ROTATE) || (cmd_op == OP_SHIFT)) begin
      cnt_load_s = cmd_steps;
      bad_idx_s  = 1'b0;
    end else begin
      cnt_load_s = CNT_W'(1);
      bad_idx_s  = (32'(cmd_idx) >= 32'(NREG));
    end
  end

  // Next-state and step counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_nxt_s   = cnt_load_s;
          state_nxt_s = (cnt_load_s != {CNT_W{1'b0}}) ? ST_RUN : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_nxt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // One step of the latched operation; all targets read the pre-step image.
  always_comb begin
    regs_nxt_s = regs_r;
    if (state_r == ST_RUN) begin
      case (op_r)
        OP_ROTATE: begin
          for (int i = 0; i < NREG-1; i++) regs_nxt_s[i] = regs_r[i+1];
          regs_nxt_s[NREG-1] = regs_r[0];
        end
        OP_SHIFT: begin
          for (int i = 0; i < NREG-1; i++) regs_nxt_s[i] = regs_r[i+1];
          regs_nxt_s[NREG-1] = data_r;
        end
        OP_LOAD: begin
          for (int i = 0; i < NREG; i++) begin
            if (idx_r == IDX_W'(i)) regs_nxt_s[i] = data_r;
            else                    regs_nxt_s[i] = regs_r[i];
          end
        end
        OP_SWAP: begin
          // idx == NREG-1 matches no iteration, so the image stays as is.
          for (int i = 0; i < NREG-1; i++) begin
            if (idx_r == IDX_W'(i)) begin
              regs_nxt_s[i]      = regs_r[NREG-1];
              regs_nxt_s[NREG-1] = regs_r[i];
            end else begin
              regs_nxt_s[i] = regs_r[i];
            end
          end
        end
        default: regs_nxt_s = regs_r;
      endcase
    end else begin
      regs_nxt_s = regs_r;
    end
  end

  // Error flag accompanies done only for a range-failed LOAD/SWAP.
  always_comb begin
    err_nxt_s = 1'b0;
    if ((state_nxt_s == ST_DONE) && (state_r == ST_RUN)) err_nxt_s = bad_idx_r;
    else                                                  err_nxt_s = 1'b0;
  end

  // State, counter and register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      regs_r  <= RST_VAL;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      regs_r  <= regs_nxt_s;
    end
  end

  // Capture the command fields on the accept edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= 2'b00;
      idx_r     <= {IDX_W{1'b0}};
      data_r    <= {WIDTH{1'b0}};
      bad_idx_r <= 1'b0;
    end else if (accept_s) begin
      op_r      <= cmd_op;
      idx_r     <= cmd_idx;
      data_r    <= cmd_data;
      bad_idx_r <= bad_idx_s;
    end else begin
      op_r      <= op_r;
      idx_r     <= idx_r;
      data_r    <= data_r;
      bad_idx_r <= bad_idx_r;
    end
  end

  // Status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s == ST_IDLE);
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      err_r   <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_reg_rotator.sv
// Self-checking bench for reg_rotator: table of directed commands, hand
// sequences for intermediate steps and reset abort, then random commands
// checked against an array/queue reference model.
module tb_reg_rotator;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int IW = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = 2'b00;
  logic [CW-1:0]   cmd_steps = '0;
  logic [IW-1:0]   cmd_idx = '0;
  logic [W-1:0]    cmd_data = '0;
  logic [N*W-1:0]  regs;
  logic            busy, done, err;

  reg_rotator #(.WIDTH(W), .NREG(N), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_steps(cmd_steps), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
    .regs(regs), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int m [N];

  typedef struct {
    int op; int steps; int idx; int data;
    int e0; int e1; int e2; int eerr;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rg(input int i);
    return {24'd0, regs[i*W +: W]};
  endfunction

  task automatic model_reset();
    m[0] = 1; m[1] = 0; m[2] = 1;
  endtask

  // Reference: whole-command effect computed directly from the operation rules.
  task automatic model_apply(input int op, input int steps, input int idx, input int data);
    int old [N];
    int q [$];
    old = m;
    case (op)
      0: if (idx < N) m[idx] = data;
      1: for (int i = 0; i < N; i++) m[i] = old[(i + steps) % N];
      2: begin
        for (int i = 0; i < N; i++) q.push_back(old[i]);
        for (int s = 0; s < steps; s++) begin
          q.push_back(data);
          void'(q.pop_front());
        end
        for (int i = 0; i < N; i++) m[i] = q[i];
      end
      default: if (idx < N) begin
        m[idx] = old[N-1];
        m[N-1] = old[idx];
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < N; i++) chk($sformatf("%s r%0d", tag, i), rg(i), 32'(m[i]));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    #2;
    model_reset();
    check_model("reset");
    chk("reset ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one command, wait for done (bounded), check latency/err/regs.
  task automatic run_cmd(input int op, input int steps, input int idx, input int data,
                         input bit noise, input string tag);
    int c;
    int exp_k;
    int exp_err;
    exp_k   = (op == 1 || op == 2) ? steps : 1;
    exp_err = ((op == 0 || op == 3) && idx >= N) ? 1 : 0;
    @(negedge clk);
    chk({tag, " ready before"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_steps = CW'(steps);
    cmd_idx   = IW'(idx);
    cmd_data  = W'(data);
    @(negedge clk);
    if (!noise) cmd_valid = 1'b0;
    for (c = 0; c < 40; c++) begin
      if (done) break;
      @(negedge clk);
      if (noise) begin
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_steps = CW'($urandom_range(0, 15));
        cmd_idx   = IW'($urandom_range(0, 3));
        cmd_data  = W'($urandom);
      end
    end
    cmd_valid = 1'b0;
    model_apply(op, steps, idx, data);
    chk({tag, " done seen"}, (c < 40) ? 32'd1 : 32'd0, 32'd1);
    chk({tag, " latency"}, 32'(c), 32'(exp_k));
    chk({tag, " err"}, {31'd0, err}, 32'(exp_err));
    chk({tag, " busy at done"}, {31'd0, busy}, 32'd1);
    check_model(tag);
    @(negedge clk);
    chk({tag, " done pulse width"}, {31'd0, done}, 32'd0);
    chk({tag, " idle ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int op, st, ix, dt, c;
    bit saw_done;

    // op steps idx data  expected r0 r1 r2  err   (chained from reset 1,0,1)
    tbl[0]  = '{1, 1, 0, 'h00,  'h00, 'h01, 'h01, 0};
    tbl[1]  = '{1, 3, 0, 'h00,  'h00, 'h01, 'h01, 0};
    tbl[2]  = '{2, 2, 0, 'hAA,  'h01, 'hAA, 'hAA, 0};
    tbl[3]  = '{0, 0, 1, 'h5A,  'h01, 'h5A, 'hAA, 0};
    tbl[4]  = '{3, 0, 1, 'h00,  'h01, 'hAA, 'h5A, 0};
    tbl[5]  = '{0, 0, 3, 'hFF,  'h01, 'hAA, 'h5A, 1};
    tbl[6]  = '{1, 0, 0, 'h00,  'h01, 'hAA, 'h5A, 0};
    tbl[7]  = '{3, 0, 2, 'h00,  'h01, 'hAA, 'h5A, 0};
    tbl[8]  = '{3, 0, 0, 'h00,  'h5A, 'hAA, 'h01, 0};
    tbl[9]  = '{3, 0, 3, 'h00,  'h5A, 'hAA, 'h01, 1};
    tbl[10] = '{2, 0, 0, 'h77,  'h5A, 'hAA, 'h01, 0};
    tbl[11] = '{0, 0, 0, 'h33,  'h33, 'hAA, 'h01, 0};

    apply_reset();

    for (int v = 0; v < 12; v++) begin
      run_cmd(tbl[v].op, tbl[v].steps, tbl[v].idx, tbl[v].data, 1'b0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d tbl r0", v), rg(0), 32'(tbl[v].e0));
      chk($sformatf("vec%0d tbl r1", v), rg(1), 32'(tbl[v].e1));
      chk($sformatf("vec%0d tbl r2", v), rg(2), 32'(tbl[v].e2));
    end

    // SHIFT 2 with fill AA from reset: observe the intermediate image.
    apply_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_steps = CW'(2); cmd_idx = '0; cmd_data = 8'hAA;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("shift accept regs r0", rg(0), 32'h01);
    chk("shift accept ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("shift step1 r0", rg(0), 32'h00);
    chk("shift step1 r1", rg(1), 32'h01);
    chk("shift step1 r2", rg(2), 32'hAA);
    chk("shift step1 done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("shift step2 r0", rg(0), 32'h01);
    chk("shift step2 r1", rg(1), 32'hAA);
    chk("shift step2 r2", rg(2), 32'hAA);
    chk("shift step2 done", {31'd0, done}, 32'd1);
    chk("shift step2 err", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("shift after done", {31'd0, done}, 32'd0);

    // ROTATE 15 aborted by reset after four steps.
    apply_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_steps = CW'(15);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort mid r0", rg(0), 32'h00);
    chk("abort mid busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort r0", rg(0), 32'h01);
    chk("abort r1", rg(1), 32'h00);
    chk("abort r2", rg(2), 32'h01);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort no done", {31'd0, saw_done}, 32'd0);
    chk("abort ready after", {31'd0, cmd_ready}, 32'd1);
    model_reset();
    check_model("abort idle");

    // Random commands, half with cmd_valid held and inputs churning while busy.
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 3);
      st = $urandom_range(0, 15);
      ix = $urandom_range(0, 3);
      dt = $urandom_range(0, 255);
      run_cmd(op, st, ix, dt, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
